// File: rtl/pipe_board_ctrl.sv
// 4x4 pipe-puzzle board: tile registers, cursor, rotation and a one-cell-per-cycle path checker.
// state  | meaning
// IDLE   | waiting for an accepted rotation
// START  | arm checker at cell 0, entering from north
// TRACE  | follow the pipe one cell per cycle
// PASS   | path reached the sink, set win
// FAIL   | path broken, clear win
module pipe_board_ctrl #(
   parameter logic [63:0] INIT_BOARD = 64'h0,
   parameter int unsigned MAX_STEPS  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_rot,
   input  logic [3:0] rd_idx,
   output logic [3:0] rd_tile,
   output logic [3:0] cursor,
   output logic       busy,
   output logic       win
);

   localparam int SW = $clog2(MAX_STEPS) + 1;
   localparam logic [1:0] DIR_N = 2'd0, DIR_E = 2'd1, DIR_S = 2'd2, DIR_W = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_START, S_TRACE, S_PASS, S_FAIL} state_t;

   // opening mask bit order: {W, S, E, N}
   function automatic logic [3:0] openings(input logic [3:0] t);
      case (t)
         4'd0:    openings = 4'b1010;
         4'd1:    openings = 4'b0101;
         4'd2:    openings = 4'b0011;
         4'd3:    openings = 4'b0110;
         4'd4:    openings = 4'b1100;
         4'd5:    openings = 4'b1001;
         default: openings = 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] rotated(input logic [3:0] t);
      case (t)
         4'd0:    rotated = 4'd1;
         4'd1:    rotated = 4'd0;
         4'd2:    rotated = 4'd3;
         4'd3:    rotated = 4'd4;
         4'd4:    rotated = 4'd5;
         4'd5:    rotated = 4'd2;
         default: rotated = t;
      endcase
   endfunction

   logic [15:0][3:0] board;
   logic             rot_go;
   state_t           state, state_nxt;
   logic [3:0]       pos, pos_nxt;
   logic [1:0]       entry, entry_nxt;
   logic [SW-1:0]    steps, steps_nxt;
   logic             busy_nxt, win_nxt;
   logic [3:0]       tile_open, rest;
   logic [1:0]       exit_dir;
   logic             nb_valid;
   logic [3:0]       nb_pos;

   // a winning board is locked: rotations are dropped and no recheck is started
   assign rot_go  = key_rot & ~win;
   assign rd_tile = board[rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         board <= INIT_BOARD;
      end else if (rot_go) begin
         board[cursor] <= rotated(board[cursor]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cursor <= 4'd0;
      end else if (key_up) begin
         if (cursor[3:2] != 2'd0) cursor <= cursor - 4'd4;
      end else if (key_down) begin
         if (cursor[3:2] != 2'd3) cursor <= cursor + 4'd4;
      end else if (key_left) begin
         if (cursor[1:0] != 2'd0) cursor <= cursor - 4'd1;
      end else if (key_right) begin
         if (cursor[1:0] != 2'd3) cursor <= cursor + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_START;
         pos   <= 4'd0;
         entry <= DIR_N;
         steps <= '0;
         busy  <= 1'b0;
         win   <= 1'b0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
         entry <= entry_nxt;
         steps <= steps_nxt;
         busy  <= busy_nxt;
         win   <= win_nxt;
      end
   end

   // exit is whichever opening remains once the entry side is removed
   always_comb begin
      tile_open = openings(board[pos]);
      rest      = tile_open & ~(4'b0001 << entry);
      exit_dir  = DIR_N;
      if (rest[1]) exit_dir = DIR_E;
      if (rest[2]) exit_dir = DIR_S;
      if (rest[3]) exit_dir = DIR_W;
      nb_valid = 1'b0;
      nb_pos   = pos;
      case (exit_dir)
         DIR_N: begin nb_valid = (pos[3:2] != 2'd0); nb_pos = pos - 4'd4; end
         DIR_E: begin nb_valid = (pos[1:0] != 2'd3); nb_pos = pos + 4'd1; end
         DIR_S: begin nb_valid = (pos[3:2] != 2'd3); nb_pos = pos + 4'd4; end
         default: begin nb_valid = (pos[1:0] != 2'd0); nb_pos = pos - 4'd1; end
      endcase
   end

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      entry_nxt = entry;
      steps_nxt = steps;
      busy_nxt  = busy;
      win_nxt   = win;
      case (state)
         S_IDLE: begin
            if (rot_go) state_nxt = S_START;
         end
         S_START: begin
            pos_nxt   = 4'd0;
            entry_nxt = DIR_N;
            steps_nxt = '0;
            busy_nxt  = 1'b1;
            state_nxt = rot_go ? S_START : S_TRACE;
         end
         S_TRACE: begin
            if (rot_go) begin
               state_nxt = S_START;
            end else if (!tile_open[entry]) begin
               state_nxt = S_FAIL;
            end else if (pos == 4'd15 && exit_dir == DIR_S) begin
               state_nxt = S_PASS;
            end else if (!nb_valid || steps == SW'(MAX_STEPS - 1)) begin
               state_nxt = S_FAIL;
            end else begin
               pos_nxt   = nb_pos;
               entry_nxt = exit_dir ^ 2'b10;
               steps_nxt = steps + 1'b1;
            end
         end
         S_PASS: begin
            win_nxt   = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = rot_go ? S_START : S_IDLE;
         end
         S_FAIL: begin
            win_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = rot_go ? S_START : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
